// File: rtl/cam_pixel_bank_writer_pkg.sv
// Shared types for the camera capture engine: FSM encoding and byte width.
// No logic; latency and backpressure are properties of the modules that import it.
package cam_pixel_bank_writer_pkg;

  localparam int CAM_BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_CAPTURE    = 2'd2,
    ST_DROP       = 2'd3
  } state_t;

  // Bytes are accepted in both CAPTURE and DROP; DROP only suppresses the write.
  function automatic logic in_capture(input state_t s);
    return (s == ST_CAPTURE) || (s == ST_DROP);
  endfunction

endpackage

// File: rtl/cam_pixel_bank_writer_sync_edge.sv
// Two-flop synchroniser plus a history flop giving registered-level rise/fall pulses.
// Latency: 2 clk to q_o, edge pulses in the same cycle as q_o changes; no backpressure.
module cam_pixel_bank_writer_sync_edge #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic [W-1:0] rise_o,
  output logic [W-1:0] fall_o
);

  logic [W-1:0] s1_q, s2_q, hist_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      s1_q   <= '0;
      s2_q   <= '0;
      hist_q <= '0;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      hist_q <= s2_q;
    end
  end

  assign q_o    = s2_q;
  assign rise_o = s2_q & ~hist_q;
  assign fall_o = ~s2_q & hist_q;

endmodule

// File: rtl/cam_pixel_bank_writer.sv
// Camera byte packer writing words into NUM_BANKS ping-pong RAM banks with full/release handshake.
// Latency: ram_we_o 4 clk after the PCLKI rise of a word's last byte; no backpressure, full banks drop words.
module cam_pixel_bank_writer
  import cam_pixel_bank_writer_pkg::*;
#(
  parameter int BYTES_PER_WORD = 4,
  parameter int NUM_BANKS      = 4,
  parameter int WORDS_PER_BANK = 512,
  parameter int VSYNC_ACT_HIGH = 1,
  parameter int CNT_W          = 16,
  localparam int DATAWIDTH     = CAM_BYTE_W * BYTES_PER_WORD,
  localparam int ADDR_W        = $clog2(WORDS_PER_BANK),
  localparam int BANK_W        = $clog2(NUM_BANKS)
) (
  input  logic                  WBs_CLK_i,
  input  logic                  WBs_RST_n_i,
  input  logic                  PCLKI,
  input  logic                  VSYNCI,
  input  logic                  HREFI,
  input  logic [7:0]            CAM_DAT,
  input  logic                  cfg_enable_i,
  input  logic                  cfg_lsb_first_i,
  input  logic [NUM_BANKS-1:0]  bank_release_i,
  output logic                  ram_we_o,
  output logic [BANK_W-1:0]     ram_bank_o,
  output logic [ADDR_W-1:0]     ram_addr_o,
  output logic [DATAWIDTH-1:0]  ram_wdata_o,
  output logic [NUM_BANKS-1:0]  bank_full_o,
  output logic [BANK_W-1:0]     cur_bank_o,
  output logic                  frame_start_o,
  output logic [CNT_W-1:0]      frame_cnt_o,
  output logic [CNT_W-1:0]      overflow_cnt_o
);

  localparam int BC_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  logic [2:0] ctrl_q, ctrl_rise, ctrl_fall;
  logic [7:0] dat_q, dat_rise, dat_fall;
  logic       edge_unused;

  cam_pixel_bank_writer_sync_edge #(.W(3)) u_sync_ctrl (
    .clk_i   (WBs_CLK_i),
    .rst_n_i (WBs_RST_n_i),
    .d_i     ({PCLKI, VSYNCI, HREFI}),
    .q_o     (ctrl_q),
    .rise_o  (ctrl_rise),
    .fall_o  (ctrl_fall)
  );

  cam_pixel_bank_writer_sync_edge #(.W(8)) u_sync_dat (
    .clk_i   (WBs_CLK_i),
    .rst_n_i (WBs_RST_n_i),
    .d_i     (CAM_DAT),
    .q_o     (dat_q),
    .rise_o  (dat_rise),
    .fall_o  (dat_fall)
  );

  assign edge_unused = ^{ctrl_q[2], ctrl_rise[0], ctrl_fall[2], ctrl_fall[0], dat_rise, dat_fall};

  state_t                state_q, state_d;
  logic [1:0]            warm_q, warm_d;
  logic                  cap_vld_q, cap_vld_d;
  logic [7:0]            cap_dat_q, cap_dat_d;
  logic [BC_W-1:0]       byte_cnt_q, byte_cnt_d;
  logic [DATAWIDTH-1:0]  word_q, word_d;
  logic                  drop_pend_q, drop_pend_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [BANK_W-1:0]     bank_q, bank_d;
  logic [NUM_BANKS-1:0]  full_q, full_d;
  logic [CNT_W-1:0]      frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]      ovf_q, ovf_d;
  logic                  frame_start_q, frame_start_d;
  logic                  we_q, we_d;
  logic [BANK_W-1:0]     wbank_q, wbank_d;
  logic [ADDR_W-1:0]     waddr_q, waddr_d;
  logic [DATAWIDTH-1:0]  wdata_q, wdata_d;

  logic                  frame_act, frame_edge, sync_ready, full_cur, last_byte;
  logic [DATAWIDTH-1:0]  packed_word;

  assign frame_act  = (VSYNC_ACT_HIGH != 0) ? ctrl_q[1] : ~ctrl_q[1];
  // The synchroniser leaves reset at 0, so a level already present would look like an edge until it settles.
  assign sync_ready = (warm_q == 2'd3);
  assign frame_edge = ((VSYNC_ACT_HIGH != 0) ? ctrl_rise[1] : ctrl_fall[1]) & sync_ready;
  assign full_cur   = full_q[bank_q];
  assign last_byte  = (byte_cnt_q == BC_W'(BYTES_PER_WORD - 1));
  assign packed_word = cfg_lsb_first_i
                     ? ((word_q >> 8) | (DATAWIDTH'(cap_dat_q) << (DATAWIDTH - 8)))
                     : ((word_q << 8) | DATAWIDTH'(cap_dat_q));

  always_comb begin
    state_d       = state_q;
    warm_d        = sync_ready ? warm_q : warm_q + 2'd1;
    cap_vld_d     = ctrl_rise[2] & ctrl_q[0] & frame_act & in_capture(state_q);
    cap_dat_d     = dat_q;
    byte_cnt_d    = byte_cnt_q;
    word_d        = word_q;
    drop_pend_d   = drop_pend_q;
    addr_d        = addr_q;
    bank_d        = bank_q;
    full_d        = full_q & ~bank_release_i;
    frame_cnt_d   = frame_cnt_q;
    ovf_d         = ovf_q;
    frame_start_d = 1'b0;
    we_d          = 1'b0;
    wbank_d       = wbank_q;
    waddr_d       = waddr_q;
    wdata_d       = wdata_q;

    if (!cfg_enable_i) begin
      state_d     = ST_IDLE;
      cap_vld_d   = 1'b0;
      byte_cnt_d  = '0;
      word_d      = '0;
      drop_pend_d = 1'b0;
      addr_d      = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_WAIT_FRAME;
        ST_WAIT_FRAME: begin
          if (frame_edge) begin
            state_d       = ST_CAPTURE;
            frame_start_d = 1'b1;
            frame_cnt_d   = frame_cnt_q + CNT_W'(1);
            byte_cnt_d    = '0;
            drop_pend_d   = 1'b0;
          end
        end
        default: begin
          if (!frame_act) begin
            state_d     = ST_WAIT_FRAME;
            byte_cnt_d  = '0;
            drop_pend_d = 1'b0;
          end else begin
            if (state_q == ST_DROP && !full_cur) state_d = ST_CAPTURE;
            if (cap_vld_q) begin
              word_d = packed_word;
              if (last_byte) begin
                byte_cnt_d  = '0;
                drop_pend_d = 1'b0;
                if (state_q == ST_CAPTURE && !full_cur && !drop_pend_q) begin
                  we_d    = 1'b1;
                  wdata_d = packed_word;
                  waddr_d = addr_q;
                  wbank_d = bank_q;
                  if (addr_q == ADDR_W'(WORDS_PER_BANK - 1)) begin
                    full_d[bank_q] = 1'b1;
                    addr_d         = '0;
                    bank_d         = bank_q + BANK_W'(1);
                  end else begin
                    addr_d = addr_q + ADDR_W'(1);
                  end
                end else begin
                  if (ovf_q != '1) ovf_d = ovf_q + CNT_W'(1);
                  if (full_cur) state_d = ST_DROP;
                end
              end else begin
                byte_cnt_d = byte_cnt_q + BC_W'(1);
                // A word begun while dropping stays dropped even if the bank frees mid-word.
                if (state_q == ST_DROP) drop_pend_d = 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge WBs_CLK_i) begin
    if (!WBs_RST_n_i) begin
      state_q       <= ST_IDLE;
      warm_q        <= '0;
      cap_vld_q     <= 1'b0;
      cap_dat_q     <= '0;
      byte_cnt_q    <= '0;
      word_q        <= '0;
      drop_pend_q   <= 1'b0;
      addr_q        <= '0;
      bank_q        <= '0;
      full_q        <= '0;
      frame_cnt_q   <= '0;
      ovf_q         <= '0;
      frame_start_q <= 1'b0;
      we_q          <= 1'b0;
      wbank_q       <= '0;
      waddr_q       <= '0;
      wdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      warm_q        <= warm_d;
      cap_vld_q     <= cap_vld_d;
      cap_dat_q     <= cap_dat_d;
      byte_cnt_q    <= byte_cnt_d;
      word_q        <= word_d;
      drop_pend_q   <= drop_pend_d;
      addr_q        <= addr_d;
      bank_q        <= bank_d;
      full_q        <= full_d;
      frame_cnt_q   <= frame_cnt_d;
      ovf_q         <= ovf_d;
      frame_start_q <= frame_start_d;
      we_q          <= we_d;
      wbank_q       <= wbank_d;
      waddr_q       <= waddr_d;
      wdata_q       <= wdata_d;
    end
  end

  assign ram_we_o       = we_q;
  assign ram_bank_o     = wbank_q;
  assign ram_addr_o     = waddr_q;
  assign ram_wdata_o    = wdata_q;
  assign bank_full_o    = full_q;
  assign cur_bank_o     = bank_q;
  assign frame_start_o  = frame_start_q;
  assign frame_cnt_o    = frame_cnt_q;
  assign overflow_cnt_o = ovf_q;

endmodule

// File: tb/tb_cam_pixel_bank_writer.sv
// Directed bench for cam_pixel_bank_writer: 4-byte words, 2 banks of 4 words, plus an active-low VSYNC instance.
module tb_cam_pixel_bank_writer;

  logic        clk = 1'b0;
  logic        rst_n, pclk, vsync, href, en, lsb;
  logic [7:0]  cam_dat;
  logic [1:0]  rel;

  logic        ram_we, ram_bank, cur_bank, frame_start;
  logic [1:0]  ram_addr, bank_full;
  logic [31:0] ram_wdata;
  logic [15:0] frame_cnt, ovf_cnt;

  logic        n_we_unused, n_bank_unused, n_cur_unused, n_fs_unused;
  logic [1:0]  n_addr_unused, n_full_unused;
  logic [31:0] n_wdata_unused;
  logic [15:0] n_frame_cnt, n_ovf_unused;

  always #5 clk = ~clk;

  cam_pixel_bank_writer #(
    .BYTES_PER_WORD(4), .NUM_BANKS(2), .WORDS_PER_BANK(4), .VSYNC_ACT_HIGH(1), .CNT_W(16)
  ) dut (
    .WBs_CLK_i(clk), .WBs_RST_n_i(rst_n), .PCLKI(pclk), .VSYNCI(vsync), .HREFI(href),
    .CAM_DAT(cam_dat), .cfg_enable_i(en), .cfg_lsb_first_i(lsb), .bank_release_i(rel),
    .ram_we_o(ram_we), .ram_bank_o(ram_bank), .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata),
    .bank_full_o(bank_full), .cur_bank_o(cur_bank), .frame_start_o(frame_start),
    .frame_cnt_o(frame_cnt), .overflow_cnt_o(ovf_cnt)
  );

  cam_pixel_bank_writer #(
    .BYTES_PER_WORD(4), .NUM_BANKS(2), .WORDS_PER_BANK(4), .VSYNC_ACT_HIGH(0), .CNT_W(16)
  ) dut_n (
    .WBs_CLK_i(clk), .WBs_RST_n_i(rst_n), .PCLKI(pclk), .VSYNCI(vsync), .HREFI(href),
    .CAM_DAT(cam_dat), .cfg_enable_i(en), .cfg_lsb_first_i(lsb), .bank_release_i(rel),
    .ram_we_o(n_we_unused), .ram_bank_o(n_bank_unused), .ram_addr_o(n_addr_unused),
    .ram_wdata_o(n_wdata_unused), .bank_full_o(n_full_unused), .cur_bank_o(n_cur_unused),
    .frame_start_o(n_fs_unused), .frame_cnt_o(n_frame_cnt), .overflow_cnt_o(n_ovf_unused)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int wr_cnt = 0;
  int fs_cnt = 0;
  int n_falls = 0;
  logic [31:0] last_data = '0;
  logic [1:0]  last_addr = '0;
  logic        last_bank = 1'b0;

  always @(negedge clk) begin
    if (ram_we) begin
      wr_cnt    = wr_cnt + 1;
      last_data = ram_wdata;
      last_addr = ram_addr;
      last_bank = ram_bank;
    end
    if (frame_start) fs_cnt = fs_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    cam_dat = b;
    pclk = 1'b1;
    tick(2);
    pclk = 1'b0;
    tick(2);
  endtask

  // Last byte is timed exactly so the write strobe position and width can be checked.
  task automatic send_word(input logic [31:0] w, input logic [1:0] r, input logic exp_we, input string tag);
    for (int i = 0; i < 3; i++) send_byte(w[31-8*i -: 8]);
    cam_dat = w[7:0];
    pclk = 1'b1;
    tick(3);
    rel = r;
    @(negedge clk);
    check({tag, "_we_early"}, 32'(ram_we), 32'(0));
    @(posedge clk); #1;
    rel = 2'b00;
    pclk = 1'b0;
    @(negedge clk);
    check({tag, "_we_at4"}, 32'(ram_we), 32'(exp_we));
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_we_width"}, 32'(ram_we), 32'(0));
    tick(1);
  endtask

  task automatic start_frame();
    int f0;
    f0 = fs_cnt;
    vsync = 1'b1;
    href = 1'b1;
    tick(6);
    check("frame_start_pulses", 32'(fs_cnt - f0), 32'(1));
  endtask

  task automatic end_frame();
    vsync = 1'b0;
    href = 1'b0;
    n_falls++;
    tick(6);
  endtask

  typedef struct {
    logic [31:0] bytes;
    logic        lsb;
    logic [31:0] exp_data;
    logic [1:0]  exp_addr;
    logic        exp_bank;
    logic [1:0]  exp_full;
    logic        exp_cur;
  } vec_t;

  vec_t vt[7];
  int   w0;

  initial begin
    vt[0] = '{32'h11223344, 1'b1, 32'h44332211, 2'd1, 1'b0, 2'b00, 1'b0};
    vt[1] = '{32'hdeadbeef, 1'b0, 32'hdeadbeef, 2'd2, 1'b0, 2'b00, 1'b0};
    vt[2] = '{32'h01020304, 1'b1, 32'h04030201, 2'd3, 1'b0, 2'b01, 1'b1};
    vt[3] = '{32'ha55a00ff, 1'b0, 32'ha55a00ff, 2'd0, 1'b1, 2'b01, 1'b1};
    vt[4] = '{32'h10203040, 1'b1, 32'h40302010, 2'd1, 1'b1, 2'b01, 1'b1};
    vt[5] = '{32'h50607080, 1'b0, 32'h50607080, 2'd2, 1'b1, 2'b01, 1'b1};
    vt[6] = '{32'h90a0b0c0, 1'b1, 32'hc0b0a090, 2'd3, 1'b1, 2'b11, 1'b0};

    rst_n = 1'b0; en = 1'b0; lsb = 1'b0; rel = 2'b00;
    pclk = 1'b0; vsync = 1'b0; href = 1'b0; cam_dat = 8'h00;

    // Reset held while the camera toggles, then enable stays low.
    tick(1);
    vsync = 1'b1; href = 1'b1;
    send_byte(8'h5a);
    send_byte(8'ha5);
    check("rst_we", 32'(ram_we), 32'(0));
    check("rst_full", 32'(bank_full), 32'(0));
    check("rst_cur_bank", 32'(cur_bank), 32'(0));
    check("rst_frame_cnt", 32'(frame_cnt), 32'(0));
    check("rst_ovf", 32'(ovf_cnt), 32'(0));
    check("rst_wdata", ram_wdata, 32'(0));
    check("rst_addr", 32'(ram_addr), 32'(0));
    check("rst_frame_start", 32'(frame_start), 32'(0));
    rst_n = 1'b1;
    vsync = 1'b0; tick(4);
    vsync = 1'b1;
    for (int i = 0; i < 4; i++) send_byte(8'(i * 17));
    vsync = 1'b0; href = 1'b0; tick(4);
    check("disabled_writes", 32'(wr_cnt), 32'(0));
    check("disabled_frames", 32'(frame_cnt), 32'(0));

    // Packing and latency.
    en = 1'b1;
    n_falls = 0;
    tick(2);
    start_frame();
    check("frame_cnt_1", 32'(frame_cnt), 32'(1));
    send_word(32'h11223344, 2'b00, 1'b1, "w0");
    check("w0_data", last_data, 32'h11223344);
    check("w0_addr", 32'(last_addr), 32'(0));
    check("w0_bank", 32'(last_bank), 32'(0));
    check("w0_count", 32'(wr_cnt), 32'(1));

    for (int i = 0; i < 7; i++) begin
      lsb = vt[i].lsb;
      send_word(vt[i].bytes, 2'b00, 1'b1, "tbl");
      check("tbl_data", last_data, vt[i].exp_data);
      check("tbl_addr", 32'(last_addr), 32'(vt[i].exp_addr));
      check("tbl_bank", 32'(last_bank), 32'(vt[i].exp_bank));
      check("tbl_full", 32'(bank_full), 32'(vt[i].exp_full));
      check("tbl_cur_bank", 32'(cur_bank), 32'(vt[i].exp_cur));
      check("tbl_count", 32'(wr_cnt), 32'(i + 2));
    end

    // Both banks full: ninth word is dropped.
    lsb = 1'b0;
    send_word(32'hcafef00d, 2'b00, 1'b0, "drop9");
    check("drop9_ovf", 32'(ovf_cnt), 32'(1));
    check("drop9_count", 32'(wr_cnt), 32'(8));
    check("drop9_full", 32'(bank_full), 32'(2'b11));

    // Release bank 0 and recover.
    rel = 2'b01;
    tick(1);
    rel = 2'b00;
    @(negedge clk);
    check("release_full", 32'(bank_full), 32'(2'b10));
    tick(1);
    send_word(32'hc0ffee11, 2'b00, 1'b1, "rec");
    check("rec_data", last_data, 32'hc0ffee11);
    check("rec_addr", 32'(last_addr), 32'(0));
    check("rec_bank", 32'(last_bank), 32'(0));
    send_word(32'h21222324, 2'b00, 1'b1, "a1");
    send_word(32'h31323334, 2'b00, 1'b1, "a2");
    send_word(32'h41424344, 2'b01, 1'b1, "setrel");
    check("set_wins_full", 32'(bank_full), 32'(2'b11));
    check("setrel_addr", 32'(last_addr), 32'(3));
    check("setrel_cur_bank", 32'(cur_bank), 32'(1));
    rel = 2'b10;
    tick(1);
    rel = 2'b00;
    tick(1);
    check("release_b1_full", 32'(bank_full), 32'(2'b01));

    // Frame boundaries.
    end_frame();
    start_frame();
    check("frame_cnt_2", 32'(frame_cnt), 32'(2));
    w0 = wr_cnt;
    send_byte(8'h77);
    send_byte(8'h88);
    end_frame();
    check("partial_discard", 32'(wr_cnt), 32'(w0));
    start_frame();
    check("frame_cnt_3", 32'(frame_cnt), 32'(3));
    send_word(32'ha1b2c3d4, 2'b00, 1'b1, "newfr");
    check("newfr_data", last_data, 32'ha1b2c3d4);
    check("newfr_addr", 32'(last_addr), 32'(0));
    check("newfr_bank", 32'(last_bank), 32'(1));
    check("newfr_ovf", 32'(ovf_cnt), 32'(1));
    check("act_low_frames", 32'(n_frame_cnt), 32'(n_falls));

    // Mid-frame disable keeps full flags, clears address.
    send_word(32'hb1b2b3b4, 2'b00, 1'b1, "m1");
    send_word(32'hb5b6b7b8, 2'b00, 1'b1, "m2");
    check("m2_addr", 32'(last_addr), 32'(2));
    en = 1'b0;
    tick(2);
    check("disable_full_kept", 32'(bank_full), 32'(2'b01));
    en = 1'b1;
    tick(2);
    end_frame();
    start_frame();
    send_word(32'he1e2e3e4, 2'b00, 1'b1, "reen");
    check("reen_addr_cleared", 32'(last_addr), 32'(0));
    check("reen_bank", 32'(last_bank), 32'(1));

    // Reset mid-word.
    send_byte(8'h99);
    send_byte(8'haa);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check("mrst_full", 32'(bank_full), 32'(0));
    check("mrst_cur_bank", 32'(cur_bank), 32'(0));
    check("mrst_frame_cnt", 32'(frame_cnt), 32'(0));
    check("mrst_ovf", 32'(ovf_cnt), 32'(0));
    check("mrst_wdata", ram_wdata, 32'(0));
    w0 = wr_cnt;
    send_word(32'hf0f1f2f3, 2'b00, 1'b0, "postrst");
    check("no_write_before_edge", 32'(wr_cnt), 32'(w0));
    end_frame();
    start_frame();
    check("mrst_frame_cnt_1", 32'(frame_cnt), 32'(1));
    send_word(32'h12345678, 2'b00, 1'b1, "fresh");
    check("fresh_data", last_data, 32'h12345678);
    check("fresh_addr", 32'(last_addr), 32'(0));
    check("fresh_bank", 32'(last_bank), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
